// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request in flight to instruction
// memory and buffers returned words with their PC in a small FIFO for the decoder.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              j_signal,
  input  logic [ADDR_W-1:0] jump,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } entry_t;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  entry_t            fifo_q [DEPTH];
  entry_t            head;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       used;
  logic              outstanding, out_nxt;
  logic [ADDR_W-1:0] fetch_pc, inflight_pc;
  logic              room, push, pop, issue, flush;

  // Slots already spoken for: buffered entries plus the one in flight.
  assign used      = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign room      = used < (CW+1)'(DEPTH);
  assign imem_addr = fetch_pc;

  assign head        = fifo_q[rd_ptr];
  assign instr_valid = ~rst & (count != '0);
  assign instr       = instr_valid ? head.instr : '0;
  assign pc_out      = instr_valid ? head.pc : '0;

  always_comb begin
    state_nxt = state;
    out_nxt   = outstanding;
    imem_req  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    issue     = 1'b0;
    flush     = 1'b0;
    if (!rst) begin
      if (j_signal) begin
        // Redirect wins; a response still owed must be swallowed in DRAIN.
        flush     = 1'b1;
        out_nxt   = outstanding & ~imem_rvalid;
        state_nxt = (outstanding & ~imem_rvalid) ? DRAIN : RUN;
      end else begin
        pop = instr_valid & instr_ready;
        case (state)
          RUN: begin
            imem_req = room & ~outstanding;
            push     = outstanding & imem_rvalid;
            issue    = imem_req & imem_gnt;
            if (issue)     out_nxt = 1'b1;
            else if (push) out_nxt = 1'b0;
          end
          DRAIN: begin
            if (imem_rvalid) begin
              out_nxt   = 1'b0;
              state_nxt = RUN;
            end
          end
          default: state_nxt = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      outstanding <= 1'b0;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (flush) begin
        fetch_pc <= jump;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) begin
          fetch_pc    <= fetch_pc + ADDR_W'(1);
          inflight_pc <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: inflight_pc, instr: imem_rdata};
  end

endmodule
